// File: rtl/mouse_master_sm.sv
// -----------------------------------------------------------------------------
// mouse_master_sm
//
// PS/2 mouse host controller. It sits upstream of the PS/2 transmitter and
// downstream of the PS/2 receiver. After power-up it runs the mouse init
// handshake:
//   send 0xFF (reset)  -> expect 0xFA (ack), 0xAA (self-test ok), 0x00 (id)
//   send 0xF4 (enable) -> expect 0xFA (ack)
// It then assembles 3-byte stream packets into status/dX/dY registers and
// pulses an interrupt for each complete packet.
//
// Parameters
//   TIMEOUT_CYCLES  per-step response timeout of every wait state, in CLK cycles
//   POWERUP_CYCLES  idle wait after reset before the first command
//
// Ports
//   CLK              in   1  system clock
//   RESET            in   1  synchronous, active-high reset
//   SEND_BYTE        out  1  one-cycle request to the transmitter
//   BYTE_TO_SEND     out  8  command byte; held until the next command
//   BYTE_SENT        in   1  one-cycle pulse from the transmitter: frame complete
//   READ_ENABLE      out  1  enables receiver byte capture
//   BYTE_READ        in   8  received byte; valid while BYTE_READY=1
//   BYTE_ERROR_CODE  in   2  receiver error, 00 = ok
//   BYTE_READY       in   1  one-cycle pulse: BYTE_READ valid
//   MOUSE_STATUS     out  8  byte 0 of the last complete packet
//   MOUSE_DX         out  8  byte 1 of the last complete packet
//   MOUSE_DY         out  8  byte 2 of the last complete packet
//   SEND_INTERRUPT   out  1  one-cycle pulse: new packet in the output registers
//   INIT_DONE        out  1  high once streaming mode is reached
// -----------------------------------------------------------------------------
module mouse_master_sm #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned POWERUP_CYCLES = 500_000
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       SEND_INTERRUPT,
  output logic       INIT_DONE
);

  // One shared counter serves both the power-up wait and the per-state timeouts,
  // so it is sized for the larger of the two.
  localparam int unsigned MaxCycles = (TIMEOUT_CYCLES > POWERUP_CYCLES) ?
                                      TIMEOUT_CYCLES : POWERUP_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 2) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] PowerupLast = CntW'(POWERUP_CYCLES - 1);

  localparam logic [7:0] CmdReset  = 8'hFF;
  localparam logic [7:0] CmdEnable = 8'hF4;
  localparam logic [7:0] RspAck    = 8'hFA;
  localparam logic [7:0] RspSelfOk = 8'hAA;
  localparam logic [7:0] RspId     = 8'h00;

  typedef enum logic [3:0] {
    StPwrWait,
    StTxRst,
    StWSentRst,
    StWAckRst,
    StWSelftest,
    StWId,
    StTxEn,
    StWSentEn,
    StWAckEn,
    StRxB0,
    StRxB1,
    StRxB2,
    StIrq
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic [7:0]      r_b0;
  logic [7:0]      r_b1;

  logic            r_send_byte;
  logic [7:0]      r_byte_to_send;
  logic            r_read_enable;
  logic [7:0]      r_status;
  logic [7:0]      r_dx;
  logic [7:0]      r_dy;
  logic            r_send_irq;
  logic            r_init_done;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  state_e          w_state_d;
  logic [CntW-1:0] w_cnt_d;
  logic            w_cnt_en;
  logic            w_byte_ok;
  logic            w_timeout;
  logic            w_read_en_d;
  logic            w_cap_b0;
  logic            w_cap_b1;
  logic            w_load_out;

  // A "byte" is only a clean reception; an error-flagged one is handled apart.
  assign w_byte_ok = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
  assign w_timeout = (r_cnt == TimeoutLast);

  // In every wait state a response is checked before the timeout, so a byte
  // landing on the expiry cycle takes priority.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StPwrWait: begin
        if (r_cnt == PowerupLast) w_state_d = StTxRst;
      end
      StTxRst: begin
        w_state_d = StWSentRst;
      end
      StWSentRst: begin
        if (BYTE_SENT)      w_state_d = StWAckRst;
        else if (w_timeout) w_state_d = StTxRst;
      end
      StWAckRst: begin
        if (BYTE_READY)     w_state_d = (w_byte_ok && BYTE_READ == RspAck) ?
                                        StWSelftest : StTxRst;
        else if (w_timeout) w_state_d = StTxRst;
      end
      StWSelftest: begin
        if (BYTE_READY)     w_state_d = (w_byte_ok && BYTE_READ == RspSelfOk) ?
                                        StWId : StTxRst;
        else if (w_timeout) w_state_d = StTxRst;
      end
      StWId: begin
        if (BYTE_READY)     w_state_d = (w_byte_ok && BYTE_READ == RspId) ?
                                        StTxEn : StTxRst;
        else if (w_timeout) w_state_d = StTxRst;
      end
      StTxEn: begin
        w_state_d = StWSentEn;
      end
      StWSentEn: begin
        if (BYTE_SENT)      w_state_d = StWAckEn;
        else if (w_timeout) w_state_d = StTxRst;
      end
      StWAckEn: begin
        if (BYTE_READY)     w_state_d = (w_byte_ok && BYTE_READ == RspAck) ?
                                        StRxB0 : StTxRst;
        else if (w_timeout) w_state_d = StTxRst;
      end
      StRxB0: begin
        // Status bytes always have bit 3 set; anything else is dropped so the
        // packet framing can re-align. Error-flagged bytes are dropped too.
        if (w_byte_ok && BYTE_READ[3]) w_state_d = StRxB1;
      end
      StRxB1: begin
        if (BYTE_READY) w_state_d = w_byte_ok ? StRxB2 : StRxB0;
      end
      StRxB2: begin
        if (BYTE_READY) w_state_d = w_byte_ok ? StIrq : StRxB0;
      end
      StIrq: begin
        w_state_d = StRxB0;
      end
      default: begin
        w_state_d = StPwrWait;
      end
    endcase
  end

  // Counter runs only in states that time something; it restarts on every
  // state change so each wait step gets its own full budget.
  always_comb begin
    w_cnt_en = 1'b0;
    case (r_state)
      StPwrWait, StWSentRst, StWAckRst, StWSelftest,
      StWId, StWSentEn, StWAckEn: w_cnt_en = 1'b1;
      default:                    w_cnt_en = 1'b0;
    endcase

    w_cnt_d = r_cnt;
    if (w_state_d != r_state) w_cnt_d = '0;
    else if (w_cnt_en)        w_cnt_d = r_cnt + CntW'(1);
  end

  // Outputs are registered from the next state so each one lines up with the
  // state it belongs to.
  always_comb begin
    w_read_en_d = 1'b0;
    case (w_state_d)
      StWAckRst, StWSelftest, StWId, StWAckEn,
      StRxB0, StRxB1, StRxB2: w_read_en_d = 1'b1;
      default:                w_read_en_d = 1'b0;
    endcase

    w_cap_b0   = (r_state == StRxB0) && (w_state_d == StRxB1);
    w_cap_b1   = (r_state == StRxB1) && (w_state_d == StRxB2);
    w_load_out = (w_state_d == StIrq);
  end

  // ---------------------------------------------------------------------------
  // State and counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= StPwrWait;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Packet capture and outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_b0           <= '0;
      r_b1           <= '0;
      r_send_byte    <= 1'b0;
      r_byte_to_send <= '0;
      r_read_enable  <= 1'b0;
      r_status       <= '0;
      r_dx           <= '0;
      r_dy           <= '0;
      r_send_irq     <= 1'b0;
      r_init_done    <= 1'b0;
    end else begin
      r_send_byte   <= (w_state_d == StTxRst) || (w_state_d == StTxEn);
      r_read_enable <= w_read_en_d;
      r_send_irq    <= w_load_out;

      if (w_state_d == StTxRst)     r_byte_to_send <= CmdReset;
      else if (w_state_d == StTxEn) r_byte_to_send <= CmdEnable;

      if (w_cap_b0) r_b0 <= BYTE_READ;
      if (w_cap_b1) r_b1 <= BYTE_READ;

      // Byte 2 goes straight to the output so the packet is visible in the
      // same cycle as the interrupt pulse.
      if (w_load_out) begin
        r_status <= r_b0;
        r_dx     <= r_b1;
        r_dy     <= BYTE_READ;
      end

      // Once streaming, only RESET clears this; stream errors never re-init.
      if ((r_state == StWAckEn) && (w_state_d == StRxB0)) r_init_done <= 1'b1;
    end
  end

  assign SEND_BYTE      = r_send_byte;
  assign BYTE_TO_SEND   = r_byte_to_send;
  assign READ_ENABLE    = r_read_enable;
  assign MOUSE_STATUS   = r_status;
  assign MOUSE_DX       = r_dx;
  assign MOUSE_DY       = r_dy;
  assign SEND_INTERRUPT = r_send_irq;
  assign INIT_DONE      = r_init_done;

endmodule

// File: tb/tb_mouse_master_sm.sv
// -----------------------------------------------------------------------------
// tb_mouse_master_sm
//
// Self-checking bench for mouse_master_sm. A small mouse model answers the
// init commands; stream bytes come from a vector table; completed packets
// are pushed to a scoreboard queue and checked when SEND_INTERRUPT fires.
// -----------------------------------------------------------------------------
module tb_mouse_master_sm;

  localparam int unsigned TO = 100;
  localparam int unsigned PU = 20;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;
  logic [7:0] MOUSE_STATUS;
  logic [7:0] MOUSE_DX;
  logic [7:0] MOUSE_DY;
  logic       SEND_INTERRUPT;
  logic       INIT_DONE;

  mouse_master_sm #(
    .TIMEOUT_CYCLES(TO),
    .POWERUP_CYCLES(PU)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .SEND_BYTE      (SEND_BYTE),
    .BYTE_TO_SEND   (BYTE_TO_SEND),
    .BYTE_SENT      (BYTE_SENT),
    .READ_ENABLE    (READ_ENABLE),
    .BYTE_READ      (BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
    .BYTE_READY     (BYTE_READY),
    .MOUSE_STATUS   (MOUSE_STATUS),
    .MOUSE_DX       (MOUSE_DX),
    .MOUSE_DY       (MOUSE_DY),
    .SEND_INTERRUPT (SEND_INTERRUPT),
    .INIT_DONE      (INIT_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] status;
    logic [7:0] dx;
    logic [7:0] dy;
  } pkt_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] err;
    logic       irq;
    logic [7:0] status;
    logic [7:0] dx;
    logic [7:0] dy;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         irq_count = 0;
  pkt_t       exp_q[$];
  logic [7:0] sent_q[$];
  pkt_t       mon_p;
  vec_t       vecs[7];

  // Monitor: log every command and check every interrupt against the queue.
  always @(negedge CLK) begin
    if (SEND_BYTE) sent_q.push_back(BYTE_TO_SEND);
    if (SEND_INTERRUPT) begin
      irq_count++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_irq: unexpected interrupt got %h/%h/%h, none expected",
                 MOUSE_STATUS, MOUSE_DX, MOUSE_DY);
      end else begin
        mon_p = exp_q.pop_front();
        if (MOUSE_STATUS !== mon_p.status || MOUSE_DX !== mon_p.dx ||
            MOUSE_DY !== mon_p.dy) begin
          n_fail++;
          $display("FAIL sb_pkt: got %h/%h/%h expected %h/%h/%h",
                   MOUSE_STATUS, MOUSE_DX, MOUSE_DY, mon_p.status, mon_p.dx, mon_p.dy);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {28'd0, SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, MOUSE_STATUS, MOUSE_DX,
               MOUSE_DY, SEND_INTERRUPT, INIT_DONE}, 64'd0);
  endtask

  task automatic rx(input logic [7:0] d, input logic [1:0] e);
    BYTE_READ       = d;
    BYTE_ERROR_CODE = e;
    BYTE_READY      = 1'b1;
    tick();
    BYTE_READY      = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic tx_done();
    BYTE_SENT = 1'b1;
    tick();
    BYTE_SENT = 1'b0;
  endtask

  task automatic wait_send(input logic [7:0] exp, input int bound, input string name,
                           output int waited);
    waited = 0;
    while (!SEND_BYTE && waited < bound) begin
      tick();
      waited++;
    end
    chk({name, "_seen"}, {63'd0, SEND_BYTE}, 64'd1);
    chk({name, "_byte"}, {56'd0, BYTE_TO_SEND}, {56'd0, exp});
  endtask

  task automatic count_to_send(output int waited);
    waited = 0;
    while (!SEND_BYTE && waited < int'(TO + PU + 20)) begin
      tick();
      waited++;
    end
  endtask

  initial begin
    int   w;
    int   irq_before;
    pkt_t p;

    vecs[0] = '{8'h00, 2'b00, 1'b0, 8'h28, 8'h05, 8'hFB};
    vecs[1] = '{8'h08, 2'b00, 1'b0, 8'h28, 8'h05, 8'hFB};
    vecs[2] = '{8'h01, 2'b00, 1'b0, 8'h28, 8'h05, 8'hFB};
    vecs[3] = '{8'h02, 2'b01, 1'b0, 8'h28, 8'h05, 8'hFB};
    vecs[4] = '{8'h09, 2'b00, 1'b0, 8'h28, 8'h05, 8'hFB};
    vecs[5] = '{8'h10, 2'b00, 1'b0, 8'h28, 8'h05, 8'hFB};
    vecs[6] = '{8'h20, 2'b00, 1'b1, 8'h09, 8'h10, 8'h20};

    RESET           = 1'b1;
    BYTE_SENT       = 1'b0;
    BYTE_READ       = 8'h00;
    BYTE_ERROR_CODE = 2'b00;
    BYTE_READY      = 1'b0;
    idle(3);
    chk_zero("reset_state");
    RESET = 1'b0;

    // Clean init
    wait_send(8'hFF, PU + 5, "init_ff", w);
    chk("init_ff_latency", w, PU);
    tick();
    chk("ff_one_cycle", {63'd0, SEND_BYTE}, 64'd0);
    chk("wsent_read_en", {63'd0, READ_ENABLE}, 64'd0);
    idle(2);
    tx_done();
    chk("wack_read_en", {63'd0, READ_ENABLE}, 64'd1);
    rx(8'hFA, 2'b00);
    idle(2);
    rx(8'hAA, 2'b00);
    idle(2);
    rx(8'h00, 2'b00);
    wait_send(8'hF4, 10, "init_f4", w);
    tick();
    idle(2);
    tx_done();
    chk("init_done_before_ack", {63'd0, INIT_DONE}, 64'd0);
    rx(8'hFA, 2'b00);
    chk("init_done_after_ack", {63'd0, INIT_DONE}, 64'd1);
    chk("init_sent_count", sent_q.size(), 2);
    if (sent_q.size() == 2) begin
      chk("init_sent_0", {56'd0, sent_q[0]}, 64'hFF);
      chk("init_sent_1", {56'd0, sent_q[1]}, 64'hF4);
    end

    // First packet
    p = '{8'h28, 8'h05, 8'hFB};
    exp_q.push_back(p);
    rx(8'h28, 2'b00);
    idle(1);
    rx(8'h05, 2'b00);
    idle(1);
    rx(8'hFB, 2'b00);
    chk("pkt_irq", {63'd0, SEND_INTERRUPT}, 64'd1);
    chk("pkt_regs", {40'd0, MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 64'h28_05FB);
    tick();
    chk("pkt_irq_one_cycle", {63'd0, SEND_INTERRUPT}, 64'd0);
    idle(2);

    // Resync / error vectors
    irq_before = irq_count;
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].irq) begin
        p = '{vecs[i].status, vecs[i].dx, vecs[i].dy};
        exp_q.push_back(p);
      end
      rx(vecs[i].data, vecs[i].err);
      chk($sformatf("vec%0d_irq", i), {63'd0, SEND_INTERRUPT}, {63'd0, vecs[i].irq});
      chk($sformatf("vec%0d_regs", i), {40'd0, MOUSE_STATUS, MOUSE_DX, MOUSE_DY},
          {40'd0, vecs[i].status, vecs[i].dx, vecs[i].dy});
      idle(2);
    end
    chk("resync_irq_count", irq_count - irq_before, 1);
    chk("stream_init_done", {63'd0, INIT_DONE}, 64'd1);
    chk("sb_empty", exp_q.size(), 0);

    // Bad self-test
    RESET = 1'b1;
    tick();
    chk_zero("reset_after_stream");
    RESET = 1'b0;
    wait_send(8'hFF, PU + 5, "bst_ff", w);
    tick();
    idle(1);
    tx_done();
    rx(8'hFA, 2'b00);
    idle(1);
    rx(8'hFC, 2'b00);
    chk("bst_retx", {63'd0, SEND_BYTE}, 64'd1);
    chk("bst_retx_byte", {56'd0, BYTE_TO_SEND}, 64'hFF);
    chk("bst_init_done", {63'd0, INIT_DONE}, 64'd0);

    // Timeout: ACK withheld after the retried 0xFF
    tick();
    idle(1);
    tx_done();
    count_to_send(w);
    chk("timeout_retx_cycles", w, TO);
    chk("timeout_retx_byte", {56'd0, BYTE_TO_SEND}, 64'hFF);
    chk("timeout_init_done", {63'd0, INIT_DONE}, 64'd0);

    // Reset while waiting for the 0xF4 frame to complete
    tick();
    idle(1);
    tx_done();
    rx(8'hFA, 2'b00);
    idle(1);
    rx(8'hAA, 2'b00);
    idle(1);
    rx(8'h00, 2'b00);
    wait_send(8'hF4, 10, "rst_f4", w);
    tick();
    RESET = 1'b1;
    tick();
    chk_zero("reset_in_wsent_en");
    RESET = 1'b0;
    count_to_send(w);
    chk("reset_resend_latency", w, PU);
    chk("reset_resend_byte", {56'd0, BYTE_TO_SEND}, 64'hFF);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
